// File: rtl/sample_walk_ctrl.sv
// Rasterizer sample walker: captures one triangle and bbox, then emits sample positions in raster order.
// Optional SAMPLE_CNT_EN adds samp_cnt_o, a saturating count of consumed samples.
module sample_walk_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]    tri_i,
  input  logic [COLORS*SIGFIG-1:0]        color_i,
  input  logic [2*2*SIGFIG-1:0]           box_i,
  input  logic                            valid_i,
  input  logic [1:0]                      ss_sel_i,
  input  logic                            halt_i,
  output logic                            halt_o,
  output logic [VERTS*AXIS*SIGFIG-1:0]    tri_o,
  output logic [COLORS*SIGFIG-1:0]        color_o,
  output logic [2*SIGFIG-1:0]             sample_o,
  output logic                            valid_o
`ifdef SAMPLE_CNT_EN
  ,
  output logic [31:0]                     samp_cnt_o
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t              state;
  logic [SIGFIG-1:0]   ll_x;
  logic [SIGFIG-1:0]   ur_x;
  logic [SIGFIG-1:0]   ur_y;
  logic [SIGFIG-1:0]   step;
  logic [SIGFIG-1:0]   cur_x;
  logic [SIGFIG-1:0]   cur_y;
  logic [SIGFIG-1:0]   step_in;

  logic signed [SIGFIG:0] nx;
  logic signed [SIGFIG:0] ny;
  logic signed [SIGFIG:0] ur_x_e;
  logic signed [SIGFIG:0] ur_y_e;
  logic                   x_over;
  logic                   y_over;

  assign cur_x = sample_o[SIGFIG-1:0];
  assign cur_y = sample_o[2*SIGFIG-1:SIGFIG];

  assign step_in = SIGFIG'(1) << (RADIX - int'(ss_sel_i));

  // One extra sign bit so boxes touching the coordinate limit never wrap.
  assign nx     = $signed({cur_x[SIGFIG-1], cur_x}) + $signed({1'b0, step});
  assign ny     = $signed({cur_y[SIGFIG-1], cur_y}) + $signed({1'b0, step});
  assign ur_x_e = $signed({ur_x[SIGFIG-1], ur_x});
  assign ur_y_e = $signed({ur_y[SIGFIG-1], ur_y});
  assign x_over = nx > ur_x_e;
  assign y_over = ny > ur_y_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid_o  <= 1'b0;
      halt_o   <= 1'b0;
      sample_o <= '0;
      tri_o    <= '0;
      color_o  <= '0;
      ll_x     <= '0;
      ur_x     <= '0;
      ur_y     <= '0;
      step     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            tri_o    <= tri_i;
            color_o  <= color_i;
            ll_x     <= box_i[SIGFIG-1:0];
            ur_x     <= box_i[3*SIGFIG-1:2*SIGFIG];
            ur_y     <= box_i[4*SIGFIG-1:3*SIGFIG];
            step     <= step_in;
            sample_o <= box_i[2*SIGFIG-1:0];
            valid_o  <= 1'b1;
            halt_o   <= 1'b1;
            state    <= WALK;
          end else begin
            valid_o  <= 1'b0;
          end
        end
        WALK: begin
          if (!halt_i) begin
            if (!x_over) begin
              sample_o[SIGFIG-1:0] <= nx[SIGFIG-1:0];
            end else if (!y_over) begin
              sample_o <= {ny[SIGFIG-1:0], ll_x};
            end else begin
              valid_o <= 1'b0;
              halt_o  <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAMPLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_o <= '0;
    end else if (valid_o && !halt_i && samp_cnt_o != 32'hFFFF_FFFF) begin
      samp_cnt_o <= samp_cnt_o + 32'd1;
    end
  end
`endif

endmodule
